// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// RISC-V NOP encoding, occupancy state enum and bubble fill constants.
package pipe_pkg;

  localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } ps_state_e;

  // A bubble carries no PC or payload; both fields are zero-filled to any width.
  localparam logic BUBBLE_PC_FILL      = 1'b0;
  localparam logic BUBBLE_PAYLOAD_FILL = 1'b0;

  localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating event counters for a pipeline stage: stall cycles, flush cycles
// and cycles with no valid output. Instantiated only under PIPE_STAGE_PERF_EN.
module pipe_stage_perf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_any,
  input  logic        bubble,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_bubble_cnt
);

  logic [2:0]  evt;
  logic [31:0] cnt_q [3];
  logic [31:0] cnt_d [3];

  assign evt = {bubble, flush_any, stall};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (evt[gi] && (cnt_q[gi] != PERF_CNT_MAX)) begin
          cnt_d[gi] = cnt_q[gi] + 32'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  assign perf_stall_cnt  = cnt_q[0];
  assign perf_flush_cnt  = cnt_q[1];
  assign perf_bubble_cnt = cnt_q[2];

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with valid/ready handshake, 2-entry skid,
// N-source flush and stall bubbles. Optional counters: PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W  = 256,
  parameter int          PC_W       = 32,
  parameter int          FLUSH_SRCS = 2,
  parameter logic [31:0] NOP_INST   = RV_NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [31:0]           in_inst,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  stall,
  input  logic [FLUSH_SRCS-1:0] flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [31:0]           out_inst,
  output logic [PAYLOAD_W-1:0]  out_payload
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_bubble_cnt
`endif
);

  localparam logic [PC_W-1:0]      BUBBLE_PC  = {PC_W{BUBBLE_PC_FILL}};
  localparam logic [PAYLOAD_W-1:0] BUBBLE_PAY = {PAYLOAD_W{BUBBLE_PAYLOAD_FILL}};

  ps_state_e state_q, state_d;
  logic                 main_valid_q, main_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [31:0]          main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [PAYLOAD_W-1:0] main_pay_q, main_pay_d, skid_pay_q, skid_pay_d;

  logic flush_any;
  logic accept;
  logic fire;

  assign flush_any = |flush;
  assign in_ready  = !skid_valid_q && !stall && !flush_any;
  assign accept    = in_valid && in_ready;
  assign fire      = main_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    main_pay_d  = main_pay_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pay_d  = skid_pay_q;

    if (flush_any) begin
      // A same-cycle fire still completes downstream; both entries are killed.
      state_d     = PS_EMPTY;
      main_pc_d   = BUBBLE_PC;
      main_inst_d = NOP_INST;
      main_pay_d  = BUBBLE_PAY;
      skid_pc_d   = BUBBLE_PC;
      skid_inst_d = NOP_INST;
      skid_pay_d  = BUBBLE_PAY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (accept) begin
            state_d     = PS_FULL;
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_pay_d  = in_payload;
          end
        end
        PS_FULL: begin
          if (fire && accept) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_pay_d  = in_payload;
          end else if (fire) begin
            state_d     = PS_EMPTY;
            main_pc_d   = BUBBLE_PC;
            main_inst_d = NOP_INST;
            main_pay_d  = BUBBLE_PAY;
          end else if (accept) begin
            state_d     = PS_SKID;
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
            skid_pay_d  = in_payload;
          end
        end
        PS_SKID: begin
          // in_ready is low here, so only the drain path can move data.
          if (fire) begin
            state_d     = PS_FULL;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            main_pay_d  = skid_pay_q;
            skid_pc_d   = BUBBLE_PC;
            skid_inst_d = NOP_INST;
            skid_pay_d  = BUBBLE_PAY;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end

    main_valid_d = (state_d != PS_EMPTY);
    skid_valid_d = (state_d == PS_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PS_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pc_q    <= BUBBLE_PC;
      main_inst_q  <= NOP_INST;
      main_pay_q   <= BUBBLE_PAY;
      skid_pc_q    <= BUBBLE_PC;
      skid_inst_q  <= NOP_INST;
      skid_pay_q   <= BUBBLE_PAY;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      main_pay_q   <= main_pay_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_pc      = main_pc_q;
  assign out_inst    = main_inst_q;
  assign out_payload = main_pay_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf u_perf (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush_any       (flush_any),
    .bubble          (!main_valid_q),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );
`endif

endmodule
